pc_fetch_unit: RTL and testbench

- Program-counter and instruction-fetch stage directly upstream of the ALU/execute datapath.
- Holds the PC and fetches each instruction over a req/ack handshake to instruction memory.
- Presents the instruction to decode, waits for execute to retire it, then selects the next PC from the NPC op, immediate, ALU result and ALU Zero flag.

---
 rtl/pc_fetch_unit_pkg.sv | 9 +
 rtl/pc_fetch_unit_if.sv | 9 +
 rtl/pc_fetch_unit_npc_calc.sv | 18 +
 rtl/pc_fetch_unit.sv | 110 +++++++++++
 tb/tb_pc_fetch_unit.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: next-PC op codes and shared constants for the fetch stage.
package pc_fetch_unit_pkg;
    typedef logic [2:0] npc_op_t;
    localparam npc_op_t NPC_PLUS4 = 3'b000;
    localparam npc_op_t NPC_BRANCH = 3'b001;
    localparam npc_op_t NPC_JUMP = 3'b010;
    localparam npc_op_t NPC_JALR = 3'b100;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: req/ack instruction-memory fetch bus.
interface pc_fetch_unit_if;
    logic req;
    logic [31:0] addr;
    logic ack;
    logic [31:0] rdata;
    modport master(output req, addr, input ack, rdata);
    modport slave(input req, addr, output ack, rdata);
endinterface

// File: rtl/pc_fetch_unit_npc_calc.sv
// pc_fetch_unit_npc_calc: combinational next-PC selector.
module pc_fetch_unit_npc_calc
    import pc_fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [31:0] alu_c,
    input  logic        zero,
    input  npc_op_t     npc_op,
    output logic [31:0] npc
);
    logic [31:0] seq;
    logic [31:0] tgt;
    assign seq = pc + 32'd4;
    assign tgt = pc + imm;
    assign npc = (npc_op == NPC_JALR) ? (alu_c & ~32'h1) :
                 (npc_op == NPC_JUMP || (npc_op == NPC_BRANCH && zero)) ? tgt : seq;
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and req/ack instruction fetch FSM.
// MISALIGN_TRAP_EN adds a trap on misaligned next-PC instead of clearing npc[1:0].
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic              clk,
    input  logic              rst,
    pc_fetch_unit_if.master   imem,
    input  npc_op_t           npc_op,
    input  logic [31:0]       imm,
    input  logic [31:0]       alu_c,
    input  logic              zero,
    input  logic              stall,
    input  logic              retire,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [31:0]       pc,
    output logic [31:0]       pc_plus4
`ifdef MISALIGN_TRAP_EN
    ,
    output logic              trap,
    output logic [31:0]       trap_addr
`endif
);
    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC
`ifdef MISALIGN_TRAP_EN
        ,
        TRAP
`endif
    } state_t;
    state_t state;
    logic [31:0] npc_raw;
    logic [31:0] npc;
    pc_fetch_unit_npc_calc u_npc_calc (
        .pc(pc),
        .imm(imm),
        .alu_c(alu_c),
        .zero(zero),
        .npc_op(npc_op),
        .npc(npc_raw)
    );
`ifdef MISALIGN_TRAP_EN
    assign npc = npc_raw;
`else
    logic unused_trap_vec;
    assign unused_trap_vec = ^TRAP_VEC;
    assign npc = {npc_raw[31:2], 2'b00};
`endif
    assign pc_plus4 = pc + 32'd4;
    assign imem.addr = pc;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pc <= PC_RESET;
            instr <= NOP_INSTR;
            instr_valid <= 1'b0;
            imem.req <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            trap <= 1'b0;
            trap_addr <= 32'h0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                    imem.req <= 1'b1;
                end
                FETCH: if (imem.ack) begin
                    instr <= imem.rdata;
                    instr_valid <= 1'b1;
                    imem.req <= 1'b0;
                    state <= EXEC;
                end
                EXEC: if (retire && !stall) begin
                    instr_valid <= 1'b0;
`ifdef MISALIGN_TRAP_EN
                    if (|npc[1:0]) begin
                        pc <= TRAP_VEC;
                        trap <= 1'b1;
                        trap_addr <= npc;
                        state <= TRAP;
                    end else
`endif
                    begin
                        pc <= npc;
                        imem.req <= 1'b1;
                        state <= FETCH;
                    end
                end
`ifdef MISALIGN_TRAP_EN
                TRAP: begin
                    trap <= 1'b0;
                    imem.req <= 1'b1;
                    state <= FETCH;
                end
`endif
                default: begin
                    state <= IDLE;
                    imem.req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed checks of fetch handshake, next-PC selection, stall and reset.
module tb_pc_fetch_unit;
    import pc_fetch_unit_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    npc_op_t npc_op = NPC_PLUS4;
    logic [31:0] imm = 32'h0;
    logic [31:0] alu_c = 32'h0;
    logic zero = 1'b0;
    logic stall = 1'b0;
    logic retire = 1'b0;
    logic [31:0] instr;
    logic instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    int n_checks = 0;
    int n_fail = 0;
`ifdef MISALIGN_TRAP_EN
    logic trap;
    logic [31:0] trap_addr;
`endif
    pc_fetch_unit_if imem ();
    pc_fetch_unit dut (
        .clk(clk),
        .rst(rst),
        .imem(imem),
        .npc_op(npc_op),
        .imm(imm),
        .alu_c(alu_c),
        .zero(zero),
        .stall(stall),
        .retire(retire),
        .instr(instr),
        .instr_valid(instr_valid),
        .pc(pc),
        .pc_plus4(pc_plus4)
`ifdef MISALIGN_TRAP_EN
        ,
        .trap(trap),
        .trap_addr(trap_addr)
`endif
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] data);
        int k = 0;
        while (!imem.req && k < 8) begin
            step();
            k++;
        end
        check({tag, "_req"}, 32'(imem.req), 32'h1);
        check({tag, "_addr"}, imem.addr, addr);
        imem.ack = 1'b1;
        imem.rdata = data;
        step();
        imem.ack = 1'b0;
        check({tag, "_instr"}, instr, data);
        check({tag, "_valid"}, 32'(instr_valid), 32'h1);
    endtask
    task automatic do_retire(input npc_op_t op, input logic [31:0] imm_v, input logic [31:0] alu_v, input logic z);
        npc_op = op;
        imm = imm_v;
        alu_c = alu_v;
        zero = z;
        retire = 1'b1;
        step();
        retire = 1'b0;
    endtask
    task automatic expect_fetch(input string tag, input logic [31:0] addr);
        check({tag, "_valid0"}, 32'(instr_valid), 32'h0);
        check({tag, "_req"}, 32'(imem.req), 32'h1);
        check({tag, "_addr"}, imem.addr, addr);
    endtask
    initial begin
        imem.ack = 1'b0;
        imem.rdata = 32'h0;
        step();
        step();
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, NOP_INSTR);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_req", 32'(imem.req), 32'h0);
        check("rst_addr", imem.addr, 32'h0);
        rst = 1'b0;
        step();
        check("idle_to_fetch_req", 32'(imem.req), 32'h1);
        check("first_addr", imem.addr, 32'h0);
        step();
        check("req_held", 32'(imem.req), 32'h1);
        imem.ack = 1'b1;
        imem.rdata = 32'h0050_0093;
        step();
        imem.ack = 1'b0;
        check("lat1_instr", instr, 32'h0050_0093);
        check("lat1_valid", 32'(instr_valid), 32'h1);
        check("exec_req_low", 32'(imem.req), 32'h0);
        check("pc_plus4_0", pc_plus4, 32'h4);
        do_retire(NPC_PLUS4, 32'h0, 32'h0, 1'b0);
        expect_fetch("plus4", 32'h4);
        fetch("zw4", 32'h4, 32'h0000_0013);
        do_retire(NPC_PLUS4, 32'h0, 32'h0, 1'b0);
        expect_fetch("plus4_8", 32'h8);
        fetch("f8", 32'h8, 32'h1111_1111);
        do_retire(NPC_BRANCH, 32'hFFFF_FFF8, 32'h0, 1'b1);
        expect_fetch("br_taken", 32'h0);
        fetch("f0", 32'h0, 32'h2222_2222);
        do_retire(NPC_JUMP, 32'h8, 32'h0, 1'b0);
        expect_fetch("jump8", 32'h8);
        fetch("f8b", 32'h8, 32'h3333_3333);
        do_retire(NPC_BRANCH, 32'hFFFF_FFF8, 32'h0, 1'b0);
        expect_fetch("br_not", 32'hC);
        fetch("fc", 32'hC, 32'h4444_4444);
`ifdef MISALIGN_TRAP_EN
        do_retire(NPC_JALR, 32'h0, 32'h0000_0125, 1'b0);
        expect_fetch("jalr", 32'h124);
        fetch("fjalr", 32'h124, 32'h5555_5555);
        npc_op = NPC_PLUS4;
        stall = 1'b1;
        retire = 1'b1;
        step();
        retire = 1'b0;
        stall = 1'b0;
        check("stall_pc", pc, 32'h124);
        check("stall_valid", 32'(instr_valid), 32'h1);
        check("stall_req", 32'(imem.req), 32'h0);
        do_retire(NPC_PLUS4, 32'h0, 32'h0, 1'b0);
        expect_fetch("after_stall", 32'h128);
`else
        do_retire(NPC_JALR, 32'h0, 32'h0000_0123, 1'b0);
        expect_fetch("jalr", 32'h120);
        fetch("fjalr", 32'h120, 32'h5555_5555);
        npc_op = NPC_PLUS4;
        stall = 1'b1;
        retire = 1'b1;
        step();
        retire = 1'b0;
        stall = 1'b0;
        check("stall_pc", pc, 32'h120);
        check("stall_valid", 32'(instr_valid), 32'h1);
        check("stall_req", 32'(imem.req), 32'h0);
        do_retire(NPC_PLUS4, 32'h0, 32'h0, 1'b0);
        expect_fetch("after_stall", 32'h124);
`endif
        rst = 1'b1;
        #1;
        check("midrst_req", 32'(imem.req), 32'h0);
        check("midrst_pc", pc, 32'h0);
        imem.ack = 1'b1;
        imem.rdata = 32'hDEAD_BEEF;
        #4;
        step();
        rst = 1'b0;
        step();
        imem.ack = 1'b0;
        check("late_ack_valid", 32'(instr_valid), 32'h0);
        check("late_ack_instr", instr, NOP_INSTR);
        expect_fetch("refetch", 32'h0);
        fetch("fr0", 32'h0, 32'h0050_0093);
        do_retire(NPC_JUMP, 32'hFFFF_FFFC, 32'h0, 1'b0);
        expect_fetch("jump_top", 32'hFFFF_FFFC);
        check("pc_plus4_wrap", pc_plus4, 32'h0);
        fetch("ftop", 32'hFFFF_FFFC, 32'h6666_6666);
        do_retire(3'b011, 32'h40, 32'h0, 1'b1);
        expect_fetch("undef_wrap", 32'h0);
        fetch("fw0", 32'h0, 32'h7777_7777);
`ifdef MISALIGN_TRAP_EN
        do_retire(NPC_JUMP, 32'h6, 32'h0, 1'b0);
        check("trap_pulse", 32'(trap), 32'h1);
        check("trap_addr", trap_addr, 32'h6);
        check("trap_req", 32'(imem.req), 32'h0);
        step();
        check("trap_end", 32'(trap), 32'h0);
        check("trap_addr_held", trap_addr, 32'h6);
        expect_fetch("trap_vec", 32'h100);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
